// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op encodings and FSM state type for the iterative multiply/divide unit
package muldiv_pkg;
    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;
    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
endpackage

// File: rtl/muldiv_signfix.sv
// muldiv_signfix: conditional two's-complement negation
// Ports: a (value), neg (negate when high), y (a or -a)
module muldiv_signfix #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic         neg,
    output logic [W-1:0] y
);
    assign y = neg ? ~a + 1'b1 : a;
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULTU/MULT/DIVU/DIV unit, WIDTH+2 cycles per operation
// Ports: clk_i/rst_i (async active-low); start_i, op_i, a_i, b_i request; kill_i abort;
//        busy_o in flight; done_o/dbz_o completion pulse; hi_o/lo_o result registers
module muldiv_unit import muldiv_pkg::*; #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             kill_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             dbz_o
);
    localparam int CW = $clog2(WIDTH) + 1;
    state_t state_q, state_d;
    logic [1:0] op_q;
    logic neg_a_q, neg_b_q, dbz_q, sgn_in, is_div, last;
    logic [WIDTH-1:0] acc_q, q_q, m_q, a_abs, b_abs, quo_fix, rem_fix;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH:0] sum, add, shl, diff;
    logic [CW-1:0] cnt_q;

    assign sgn_in = op_i == OP_MULT || op_i == OP_DIV;
    assign is_div = op_q == OP_DIVU || op_q == OP_DIV;
    assign last   = cnt_q == CW'(WIDTH - 1);
    assign busy_o = state_q != IDLE;

    muldiv_signfix #(.W(WIDTH)) u_abs_a (.a(a_i), .neg(sgn_in & a_i[WIDTH-1]), .y(a_abs));
    muldiv_signfix #(.W(WIDTH)) u_abs_b (.a(b_i), .neg(sgn_in & b_i[WIDTH-1]), .y(b_abs));
    muldiv_signfix #(.W(2*WIDTH)) u_fix_p (.a({acc_q, q_q}), .neg(neg_a_q ^ neg_b_q), .y(prod_fix));
    muldiv_signfix #(.W(WIDTH)) u_fix_q (.a(q_q), .neg(neg_a_q ^ neg_b_q), .y(quo_fix));
    muldiv_signfix #(.W(WIDTH)) u_fix_r (.a(acc_q), .neg(neg_a_q), .y(rem_fix));

    // Multiply: {acc,q} >> 1 after optionally adding the multiplicand into acc.
    assign sum  = {1'b0, acc_q} + {1'b0, m_q};
    assign add  = q_q[0] ? sum : {1'b0, acc_q};
    // Divide: acc < m always holds, so the top bit of the (W+1)-bit difference is the borrow.
    assign shl  = {acc_q, q_q[WIDTH-1]};
    assign diff = shl - {1'b0, m_q};

    always_comb begin
        state_d = kill_i ? IDLE :
                  state_q == IDLE ? (start_i ? RUN : IDLE) :
                  state_q == RUN  ? (last ? FIX : RUN) : IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            op_q    <= OP_MULTU;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
            dbz_q   <= 1'b0;
            acc_q   <= '0;
            q_q     <= '0;
            m_q     <= '0;
            cnt_q   <= '0;
            done_o  <= 1'b0;
            dbz_o   <= 1'b0;
            hi_o    <= '0;
            lo_o    <= '0;
        end else begin
            state_q <= state_d;
            done_o  <= state_q == FIX && !kill_i;
            dbz_o   <= state_q == FIX && !kill_i && dbz_q;
            if (state_q == IDLE && state_d == RUN) begin
                op_q    <= op_i;
                neg_a_q <= sgn_in & a_i[WIDTH-1];
                neg_b_q <= sgn_in & b_i[WIDTH-1];
                dbz_q   <= op_i[1] && b_i == '0;
                acc_q   <= '0;
                q_q     <= a_abs;
                m_q     <= b_abs;
                cnt_q   <= '0;
            end else if (state_q == RUN) begin
                cnt_q <= cnt_q + 1'b1;
                acc_q <= is_div ? (diff[WIDTH] ? shl[WIDTH-1:0] : diff[WIDTH-1:0]) : add[WIDTH:1];
                q_q   <= is_div ? {q_q[WIDTH-2:0], ~diff[WIDTH]} : {add[0], q_q[WIDTH-1:1]};
            end
            if (state_q == FIX && !kill_i) begin
                hi_o <= is_div ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
                lo_o <= is_div ? (dbz_q ? '1 : quo_fix) : prod_fix[WIDTH-1:0];
            end
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: table-driven, corner-case and randomized checks of muldiv_unit against an arithmetic model
module tb_muldiv_unit;
    import muldiv_pkg::*;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a, b, hi, lo;
        logic        dbz;
    } vec_t;

    logic clk = 0, rst_i = 0, start_i = 0, kill_i = 0;
    logic [1:0] op_i = 0;
    logic [31:0] a_i = 0, b_i = 0;
    logic busy_o, done_o, dbz_o;
    logic [31:0] hi_o, lo_o;
    int vectors = 0, miscompares = 0;
    vec_t tbl[10];

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .op_i(op_i), .a_i(a_i), .b_i(b_i),
        .kill_i(kill_i), .busy_o(busy_o), .done_o(done_o), .hi_o(hi_o), .lo_o(lo_o), .dbz_o(dbz_o)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] h, output logic [31:0] l, output logic d);
        longint p;
        d = 0;
        if (op == OP_MULTU) begin
            p = longint'({32'b0, a}) * longint'({32'b0, b});
            {h, l} = p;
        end else if (op == OP_MULT) begin
            p = longint'($signed(a)) * longint'($signed(b));
            {h, l} = p;
        end else if (b == 0) begin
            l = '1; h = a; d = 1;
        end else if (op == OP_DIVU) begin
            l = a / b; h = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            l = a; h = 0;
        end else begin
            l = 32'($signed(a) / $signed(b));
            h = 32'($signed(a) % $signed(b));
        end
    endtask

    // Called one step after an edge with the unit idle or in its done cycle.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el, input logic ed, input string tag);
        int k;
        op_i = op; a_i = a; b_i = b; start_i = 1;
        @(posedge clk); #1;
        start_i = 0;
        k = 0;
        while (!done_o && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        chk({tag, " latency"}, 64'(k), 64'd33);
        chk({tag, " busy@done"}, 64'(busy_o), 64'd0);
        chk({tag, " hi"}, 64'(hi_o), 64'(eh));
        chk({tag, " lo"}, 64'(lo_o), 64'(el));
        chk({tag, " dbz"}, 64'(dbz_o), 64'(ed));
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] eh, el;
        logic ed, seen;
        tbl[0] = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        tbl[1] = '{OP_MULT,  32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0};
        tbl[2] = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        tbl[3] = '{OP_DIVU,  32'd100,       32'd7,        32'd2,         32'd14,        1'b0};
        tbl[4] = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD, 1'b0};
        tbl[5] = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0,       1'b0};
        tbl[6] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,        32'h8000_0000, 1'b0};
        tbl[7] = '{OP_MULTU, 32'd6,         32'd7,        32'd0,         32'd42,        1'b0};
        tbl[8] = '{OP_DIV,   32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1};
        tbl[9] = '{OP_DIVU,  32'd7,         32'd0,        32'd7,         32'hFFFF_FFFF, 1'b1};

        repeat (2) @(posedge clk);
        #1;
        chk("rst busy", 64'(busy_o), 0);
        chk("rst done", 64'(done_o), 0);
        chk("rst dbz", 64'(dbz_o), 0);
        chk("rst hi", 64'(hi_o), 0);
        chk("rst lo", 64'(lo_o), 0);
        rst_i = 1;
        @(posedge clk); #1;

        foreach (tbl[i]) run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].lo, tbl[i].dbz, $sformatf("tbl%0d", i));

        @(posedge clk); #1;
        chk("pulse done", 64'(done_o), 0);
        chk("pulse dbz", 64'(dbz_o), 0);
        chk("hold hi", 64'(hi_o), 64'd7);
        chk("hold lo", 64'(lo_o), 64'hFFFF_FFFF);

        // Kill at cycle 10 of a MULTU, with an ignored start pulse while busy.
        op_i = OP_MULTU; a_i = 6; b_i = 7; start_i = 1;
        @(posedge clk); #1;
        start_i = 0;
        for (int c = 1; c <= 9; c++) begin
            @(posedge clk); #1;
            if (c == 4) begin op_i = OP_DIV; a_i = 1; b_i = 1; start_i = 1; end
            if (c == 5) start_i = 0;
        end
        chk("kill busy before", 64'(busy_o), 1);
        kill_i = 1;
        @(posedge clk); #1;
        kill_i = 0;
        chk("kill busy after", 64'(busy_o), 0);
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            seen |= done_o | dbz_o | busy_o;
        end
        chk("kill no done", 64'(seen), 0);
        chk("kill hi", 64'(hi_o), 64'd7);
        chk("kill lo", 64'(lo_o), 64'hFFFF_FFFF);
        start_i = 1; kill_i = 1;
        @(posedge clk); #1;
        start_i = 0; kill_i = 0;
        chk("idle kill blocks", 64'(busy_o), 0);

        // Asynchronous reset mid-DIV.
        op_i = OP_DIV; a_i = 100; b_i = 3; start_i = 1;
        @(posedge clk); #1;
        start_i = 0;
        repeat (20) @(posedge clk);
        #1;
        rst_i = 0;
        #1;
        chk("arst busy", 64'(busy_o), 0);
        chk("arst done", 64'(done_o), 0);
        chk("arst dbz", 64'(dbz_o), 0);
        chk("arst hi", 64'(hi_o), 0);
        chk("arst lo", 64'(lo_o), 0);
        #2 rst_i = 1;
        @(posedge clk); #1;
        run_op(OP_MULTU, 2, 3, 0, 6, 0, "post-rst");

        for (int i = 0; i < 150; i++) begin
            logic [1:0] op;
            logic [31:0] a, b;
            op = 2'($urandom_range(0, 3));
            a = pick();
            b = pick();
            model(op, a, b, eh, el, ed);
            run_op(op, a, b, eh, el, ed, $sformatf("rnd%0d op%0d %h %h", i, op, a, b));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
